// File: rtl/gf163_pkg.sv
// -----------------------------------------------------------------------------
// gf163_pkg
// Shared constants and types for the GF(2^163) multiply controller.
//   GF163_M     : field degree (163)
//   GF163_PW    : width of the unreduced carry-less product (2*163-1 = 325)
//   GF163_POLY  : reduction polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1
//   gf163_state_e : controller FSM states
//   gf163_clmul82 : 82x82 carry-less multiply, building block of Karatsuba
// -----------------------------------------------------------------------------
package gf163_pkg;

  localparam int GF163_M  = 163;
  localparam int GF163_PW = 325;

  // Bit i is the coefficient of x^i; low byte 1100_1001 = x^7+x^6+x^3+1.
  localparam logic [163:0] GF163_POLY = {1'b1, 155'd0, 8'b1100_1001};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RED  = 2'd2,
    ST_DONE = 2'd3
  } gf163_state_e;

  // Schoolbook carry-less product of two 82-bit polynomials (degree <= 162).
  function automatic logic [162:0] gf163_clmul82(input logic [81:0] a,
                                                 input logic [81:0] b);
    logic [162:0] acc;
    acc = 163'd0;
    for (int i = 0; i < 82; i++) begin
      if (b[i]) begin
        acc = acc ^ ({81'd0, a} << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf163_kmul.sv
// -----------------------------------------------------------------------------
// gf163_kmul
// Combinational 163x163 carry-less multiplier, one Karatsuba level over
// 82-bit halves (high half zero-padded from 81 bits).
//   i_a, i_b : 163-bit operands, bit i = coefficient of x^i
//   o_p      : 325-bit unreduced product
// -----------------------------------------------------------------------------
module gf163_kmul
  import gf163_pkg::*;
(
  input  logic [162:0] i_a,
  input  logic [162:0] i_b,
  output logic [324:0] o_p
);

  logic [81:0]  w_al, w_ah, w_bl, w_bh;
  logic [162:0] w_ll, w_hh, w_mm, w_mid;

  assign w_al = i_a[81:0];
  assign w_ah = {1'b0, i_a[162:82]};
  assign w_bl = i_b[81:0];
  assign w_bh = {1'b0, i_b[162:82]};

  assign w_ll = gf163_clmul82(w_al, w_bl);
  assign w_hh = gf163_clmul82(w_ah, w_bh);
  assign w_mm = gf163_clmul82(w_al ^ w_ah, w_bl ^ w_bh);

  // Cross term (al*bh + ah*bl) recovered from the middle product.
  assign w_mid = w_mm ^ w_ll ^ w_hh;

  assign o_p = {162'd0, w_ll}
             ^ ({162'd0, w_mid} << 7'd82)
             ^ ({162'd0, w_hh}  << 8'd164);

endmodule

// File: rtl/gf163_reduce.sv
// -----------------------------------------------------------------------------
// gf163_reduce
// Combinational reduction of a 325-bit carry-less product modulo
// f(x) = x^163 + x^7 + x^6 + x^3 + 1.
//   i_p : 325-bit unreduced product
//   o_c : 163-bit reduced field element
// -----------------------------------------------------------------------------
module gf163_reduce
  import gf163_pkg::*;
(
  input  logic [324:0] i_p,
  output logic [162:0] o_c
);

  logic [324:0] w_t;

  // Fold terms from the top down; each fold only touches lower bits, so a
  // single descending pass clears everything above x^162.
  always_comb begin
    w_t = i_p;
    for (int i = 324; i >= 163; i--) begin
      if (w_t[i]) begin
        w_t = w_t ^ ({161'd0, GF163_POLY} << (i - 163));
      end else begin
        w_t = w_t;
      end
    end
  end

  assign o_c = w_t[162:0];

endmodule

// File: rtl/gf163_mul_ctrl.sv
// -----------------------------------------------------------------------------
// gf163_mul_ctrl
// Two-requester GF(2^163) multiply controller: round-robin grant, Karatsuba
// multiply, registered reduction, result held until the consumer accepts.
// One operation in flight; handshake at cycle T gives rsp_valid at T+3.
//   clk, rst              : clock, synchronous active-high reset
//   reqN_valid/ready      : requester N handshake (ready only in IDLE)
//   reqN_a, reqN_b        : requester N operands (163 bits)
//   rsp_valid/rsp_ready   : result handshake
//   rsp_c, rsp_id         : reduced product, index of issuing requester
//   busy                  : high whenever the FSM is not in IDLE
//   perf_ops              : (only with GF163_MUL_CTRL_PERF_EN) saturating
//                           count of completed result handshakes
// Optional macro: GF163_MUL_CTRL_PERF_EN
// -----------------------------------------------------------------------------
module gf163_mul_ctrl
  import gf163_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [162:0] req0_a,
  input  logic [162:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [162:0] req1_a,
  input  logic [162:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [162:0] rsp_c,
  output logic         rsp_id,
  output logic         busy
`ifdef GF163_MUL_CTRL_PERF_EN
  ,
  output logic [15:0]  perf_ops
`endif
);

  gf163_state_e r_state;
  logic [162:0] r_a, r_b, r_rsp_c;
  logic [324:0] r_prod;
  logic         r_id, r_last, r_rsp_valid, r_rsp_id, r_busy;

  logic         w_any, w_gnt_id, w_grant;
  logic [324:0] w_prod;
  logic [162:0] w_red;

  gf163_kmul u_kmul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  gf163_reduce u_reduce (
    .i_p (r_prod),
    .o_c (w_red)
  );

  // On a tie the requester that was not granted last wins; r_last resets
  // to 1 so requester 0 wins the first tie. rst masks any handshake.
  assign w_any      = req0_valid | req1_valid;
  assign w_gnt_id   = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_grant    = (r_state == ST_IDLE) & w_any & ~rst;
  assign req0_ready = w_grant & ~w_gnt_id;
  assign req1_ready = w_grant &  w_gnt_id;

  // Controller FSM: grant/latch, multiply, reduce, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= 163'd0;
      r_b         <= 163'd0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_prod      <= 325'd0;
      r_rsp_c     <= 163'd0;
      r_rsp_id    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_a     <= w_gnt_id ? req1_a : req0_a;
            r_b     <= w_gnt_id ? req1_b : req0_b;
            r_id    <= w_gnt_id;
            r_last  <= w_gnt_id;
            r_busy  <= 1'b1;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_prod  <= w_prod;
          r_state <= ST_RED;
        end
        ST_RED: begin
          r_rsp_c     <= w_red;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_c     = r_rsp_c;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;

`ifdef GF163_MUL_CTRL_PERF_EN
  logic [15:0] r_perf_ops;

  // Saturating count of completed result handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ops <= 16'd0;
    end else if ((r_state == ST_DONE) && rsp_ready && (r_perf_ops != 16'hFFFF)) begin
      r_perf_ops <= r_perf_ops + 16'd1;
    end
  end

  assign perf_ops = r_perf_ops;
`endif

endmodule

// File: tb/tb_gf163_mul_ctrl.sv
module tb_gf163_mul_ctrl;

  logic         clk = 1'b0;
  logic         rst, req0_valid, req1_valid, rsp_ready;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [162:0] req0_a, req0_b, req1_a, req1_b, rsp_c;
`ifdef GF163_MUL_CTRL_PERF_EN
  logic [15:0]  perf_ops;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [162:0] x162, x82, exp324, all1;

  always #5 clk = ~clk;

  gf163_mul_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_c      (rsp_c),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef GF163_MUL_CTRL_PERF_EN
    ,
    .perf_ops   (perf_ops)
`endif
  );

  task automatic check(input string tag, input logic [162:0] obs, input logic [162:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for rsp_valid; an expired bound shows as a failed check.
  task automatic wait_rsp(input string tag);
    int k;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check({tag, "_rsp_arrives"}, rsp_valid, 163'd1);
  endtask

  // Single-requester operation with exact latency and result checks.
  task automatic single_op(input logic id, input logic [162:0] a, input logic [162:0] b,
                           input logic [162:0] exp, input string tag);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    check({tag, "_ready0"}, req0_ready, {162'd0, ~id});
    check({tag, "_ready1"}, req1_ready, {162'd0, id});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_vld_t1"}, rsp_valid, 163'd0);
    check({tag, "_busy_t1"}, busy, 163'd1);
    tick();
    check({tag, "_vld_t2"}, rsp_valid, 163'd0);
    tick();
    check({tag, "_vld_t3"}, rsp_valid, 163'd1);
    check({tag, "_c"}, rsp_c, exp);
    check({tag, "_id"}, rsp_id, {162'd0, id});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_vld_after"}, rsp_valid, 163'd0);
    check({tag, "_busy_after"}, busy, 163'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    x162   = 163'd1 << 162;
    x82    = 163'd1 << 82;
    exp324 = (163'd1 << 161) | 163'h1422;  // x^324 mod f = x^161+x^12+x^10+x^5+x
    all1   = ~163'd0;

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 163'd0; req0_b = 163'd0; req1_a = 163'd0; req1_b = 163'd0;
    tick();
    tick();
    // Reset must win over pending requests.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 163'd0);
    check("rst_ready1", req1_ready, 163'd0);
    tick();
    check("rst_busy", busy, 163'd0);
    check("rst_vld", rsp_valid, 163'd0);
    check("rst_c", rsp_c, 163'd0);
    check("rst_id", rsp_id, 163'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    single_op(1'b0, 163'd1, 163'd2, 163'd2, "r028");
    single_op(1'b1, x162, 163'd2, 163'hC9, "r029");
    single_op(1'b1, x162, x162, exp324, "x324");
    single_op(1'b0, x82, x82, 163'h192, "x164");
    single_op(1'b0, 163'd0, all1, 163'd0, "zero");

    // Both requesters valid continuously from reset: 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_a = 163'd3; req0_b = 163'd3;   // (x+1)^2 = x^2+1
    req1_a = 163'd6; req1_b = 163'd5;   // (x^2+x)(x^2+1) = x^4+x^3+x^2+x
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int j;
      logic eid;
      eid = (k % 2) == 1;
      j = 0;
      while (!(req0_ready | req1_ready) && j < 10) begin
        tick();
        j++;
      end
      check("rr_ready0", req0_ready, {162'd0, ~eid});
      check("rr_ready1", req1_ready, {162'd0, eid});
      tick();
      wait_rsp("rr");
      check("rr_id", rsp_id, {162'd0, eid});
      check("rr_c", rsp_c, eid ? 163'h1E : 163'h5);
      check("rr_no_grant_done", {req0_ready, req1_ready}, 163'd0);
      tick();
    end

    // Back-pressure: result held for 6 cycles, no grant meanwhile.
    rsp_ready = 1'b0;
    req0_a = 163'd5; req0_b = 163'd7;   // (x^2+1)(x^2+x+1) = x^4+x^3+x+1
    #1;
    check("hold_grant0", req0_ready, 163'd1);
    tick();
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      check("hold_vld", rsp_valid, 163'd1);
      check("hold_c", rsp_c, 163'h1B);
      check("hold_ready", {req0_ready, req1_ready}, 163'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hold_next_rr1", req1_ready, 163'd1);
    check("hold_next_rr0", req0_ready, 163'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Reset during RED discards the operation.
    req0_valid = 1'b1; req0_a = 163'd3; req0_b = 163'd3;
    #1;
    check("red_grant", req0_ready, 163'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("red_rst_vld", rsp_valid, 163'd0);
    check("red_rst_busy", busy, 163'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("red_no_rsp", rsp_valid, 163'd0);
    end
    req0_a = 163'd5; req0_b = 163'd7;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("post_rst_tie0", req0_ready, 163'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp("post_rst");
    check("post_rst_id", rsp_id, 163'd0);
    check("post_rst_c", rsp_c, 163'h1B);
    tick();
    rsp_ready = 1'b0;

`ifdef GF163_MUL_CTRL_PERF_EN
    single_op(1'b0, 163'd1, 163'd2, 163'd2, "perf_a");
    single_op(1'b1, 163'd3, 163'd3, 163'd5, "perf_b");
    check("perf_3", perf_ops, 163'd3);
    force dut.r_perf_ops = 16'hFFFF;
    #1;
    release dut.r_perf_ops;
    single_op(1'b0, 163'd1, 163'd2, 163'd2, "perf_c");
    check("perf_sat", perf_ops, 163'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
